// File: rtl/acc_result_ring_wrapper.sv
// acc_result_ring_wrapper: config-port decode shell around a pipelined accelerator.
// Stages operand words, dispatches jobs on START, reserves a ring slot per job,
// captures results in issue order and returns them via config loads or a pop port.
// Optional: define ACC_RING_DROP_COUNT_EN for a saturating drop counter in status[47:32].
module acc_result_ring_wrapper #(
  parameter int DEPTH         = 16,
  parameter int PTR_BITS      = 4,
  parameter int OPERAND_WORDS = 4,
  parameter int RESULT_WORDS  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          config_hsk,
  input  logic [15:0]                   config_addr,
  input  logic [63:0]                   config_data,
  input  logic                          config_load,
  output logic                          cfg_ready,
  output logic                          rd_valid,
  output logic [63:0]                   rd_data,
  output logic                          acc_in_valid,
  input  logic                          acc_in_ready,
  output logic [OPERAND_WORDS*64-1:0]   acc_in_data,
  input  logic                          acc_out_valid,
  input  logic [RESULT_WORDS*64-1:0]    acc_out_data,
  output logic                          buffer_val,
  output logic [RESULT_WORDS*64-1:0]    buffer_data,
  input  logic                          buffer_pop,
  output logic [PTR_BITS-1:0]           buffer_idx,
  output logic [DEPTH-1:0]              buffer_entries_val,
  output logic [PTR_BITS:0]             occupancy,
  output logic                          err
);
  localparam int          RW       = RESULT_WORDS*64;
  localparam logic [15:0] A_OPND   = 16'h0100;
  localparam logic [15:0] A_START  = 16'h0200;
  localparam logic [15:0] A_RES    = 16'h0300;
  localparam logic [15:0] A_STAT   = 16'h0400;
  localparam logic [15:0] A_CLR    = 16'h0408;
  localparam logic [PTR_BITS:0] OCC_FULL = (PTR_BITS+1)'(DEPTH);

  logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d, curr_q, curr_d;
  logic [PTR_BITS:0]   occ_q, occ_d, issued_q, issued_d;
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [DEPTH-1:0][RW-1:0]            ent_q, ent_d;
  logic [OPERAND_WORDS-1:0][63:0]      opnd_q, opnd_d;
  logic                acc_in_valid_q, acc_in_valid_d;
  logic                rd_valid_q, rd_valid_d;
  logic [63:0]         rd_data_q, rd_data_d;
  logic                err_q, err_d;
  logic [15:0]         drop_cnt;
  logic [63:0]         status, rdata;

  logic is_ld, is_st, start_req, start_ok, start_drop, fill, orphan, ld_pop, pop, clr;
  logic full, empty;

  assign full       = (occ_q == OCC_FULL);
  assign empty      = (occ_q == '0);
  assign cfg_ready  = !full && !acc_in_valid_q;
  assign is_ld      = config_hsk && config_load;
  assign is_st      = config_hsk && !config_load;
  assign start_req  = is_st && (config_addr == A_START);
  assign start_ok   = start_req && cfg_ready;
  assign start_drop = start_req && !cfg_ready;
  assign clr        = is_st && (config_addr == A_CLR);
  // An issued count of zero means nobody is waiting for this result (e.g. after reset).
  assign fill       = acc_out_valid && (issued_q != '0);
  assign orphan     = acc_out_valid && (issued_q == '0);
  assign buffer_val = vld_q[head_q];
  // Reading the last result word consumes the entry, so a load sequence drains the ring.
  assign ld_pop     = is_ld && (config_addr == A_RES + 16'(8*(RESULT_WORDS-1)));
  assign pop        = (buffer_pop || ld_pop) && buffer_val;

`ifdef ACC_RING_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;
  logic [1:0]  drop_ev;
  // Saturating count of dropped STARTs and orphan results; a clear store resets it.
  always_comb begin
    drop_ev = {1'b0, start_drop} + {1'b0, orphan};
    drop_d  = clr ? 16'h0 : drop_q;
    if (drop_ev != 2'd0)
      drop_d = (drop_d > 16'hFFFF - 16'(drop_ev)) ? 16'hFFFF : drop_d + 16'(drop_ev);
  end
  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'h0;
`endif

  // Status word and load-data mux; unmapped loads return zero.
  always_comb begin
    status = '0;
    status[47:32]        = drop_cnt;
    status[PTR_BITS+3:3] = occ_q;
    status[2]            = full;
    status[1]            = empty;
    status[0]            = err_q;
    rdata = '0;
    for (int j = 0; j < RESULT_WORDS; j++)
      if (config_addr == A_RES + 16'(8*j)) rdata = ent_q[head_q][j*64 +: 64];
    if (config_addr == A_STAT) rdata = status;
  end

  // Next-state: pointers, counts, ring contents, operand staging, response and error.
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    curr_d         = curr_q;
    occ_d          = occ_q;
    issued_d       = issued_q;
    vld_d          = vld_q;
    ent_d          = ent_q;
    opnd_d         = opnd_q;
    acc_in_valid_d = acc_in_valid_q;
    rd_valid_d     = is_ld;
    rd_data_d      = is_ld ? rdata : rd_data_q;
    err_d          = err_q;

    // Operands are frozen while a job is waiting on the accelerator.
    if (is_st && !acc_in_valid_q)
      for (int i = 0; i < OPERAND_WORDS; i++)
        if (config_addr == A_OPND + 16'(8*i)) opnd_d[i] = config_data;

    if (start_ok) begin
      acc_in_valid_d = 1'b1;
      tail_d         = tail_q + PTR_BITS'(1);
    end else if (acc_in_valid_q && acc_in_ready) begin
      acc_in_valid_d = 1'b0;
    end

    if (fill) begin
      ent_d[curr_q] = acc_out_data;
      vld_d[curr_q] = 1'b1;
      curr_d        = curr_q + PTR_BITS'(1);
    end

    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_BITS'(1);
    end

    if (start_ok && !pop)      occ_d = occ_q + (PTR_BITS+1)'(1);
    else if (!start_ok && pop) occ_d = occ_q - (PTR_BITS+1)'(1);

    if (start_ok && !fill)      issued_d = issued_q + (PTR_BITS+1)'(1);
    else if (!start_ok && fill) issued_d = issued_q - (PTR_BITS+1)'(1);

    if (clr)                   err_d = 1'b0;
    if (start_drop || orphan)  err_d = 1'b1;
  end

  // State registers; ring data resets to a recognisable per-index pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      curr_q         <= '0;
      occ_q          <= '0;
      issued_q       <= '0;
      vld_q          <= '0;
      opnd_q         <= '0;
      acc_in_valid_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        for (int w = 0; w < RESULT_WORDS; w++)
          ent_q[i][w*64 +: 64] <= {48'hDEAD_BEEF_0000, 16'(i)};
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      curr_q         <= curr_d;
      occ_q          <= occ_d;
      issued_q       <= issued_d;
      vld_q          <= vld_d;
      ent_q          <= ent_d;
      opnd_q         <= opnd_d;
      acc_in_valid_q <= acc_in_valid_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      err_q          <= err_d;
    end
  end

  assign rd_valid           = rd_valid_q;
  assign rd_data            = rd_data_q;
  assign acc_in_valid       = acc_in_valid_q;
  assign acc_in_data        = opnd_q;
  assign buffer_data        = ent_q[head_q];
  assign buffer_idx         = head_q;
  assign buffer_entries_val = vld_q;
  assign occupancy          = occ_q;
  assign err                = err_q;

endmodule
